// File: rtl/compare_result_if.sv
// compare_result_if: comparator flag sample inputs and debounced relation/counter outputs
interface compare_result_if #(parameter int CNT_W = 8);
   logic             in_valid;
   logic             greater;
   logic             lesser;
   logic             equal;
   logic             clr_cnt;
   logic [1:0]       state;
   logic             state_chg;
   logic [3:0]       run_len;
   logic [CNT_W-1:0] gt_cnt;
   logic [CNT_W-1:0] lt_cnt;
   logic [CNT_W-1:0] eq_cnt;
   logic             err;
   modport master (
      output in_valid, greater, lesser, equal, clr_cnt,
      input  state, state_chg, run_len, gt_cnt, lt_cnt, eq_cnt, err
   );
   modport slave (
      input  in_valid, greater, lesser, equal, clr_cnt,
      output state, state_chg, run_len, gt_cnt, lt_cnt, eq_cnt, err
   );
endinterface

// File: rtl/compare_result_tracker.sv
// compare_result_tracker: debounces comparator flags into a stable relation state,
// counts legal outcomes with saturation and flags illegal flag combinations
module compare_result_tracker #(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input logic             clk,
   input logic             rst,
   compare_result_if.slave bus
);
   typedef enum logic [1:0] {UNKNOWN = 2'b00, LESS = 2'b01, EQUAL = 2'b10, GREATER = 2'b11} rel_t;
   localparam logic [3:0]       DB  = 4'(DEBOUNCE);
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   rel_t             st_q, st_d, cand_q, cand_d, rel;
   logic [3:0]       len_q, len_d;
   logic             chg_q, chg_d, err_q, err_d, legal;
   logic [CNT_W-1:0] gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= UNKNOWN;
         cand_q <= UNKNOWN;
         len_q  <= '0;
         chg_q  <= 1'b0;
         err_q  <= 1'b0;
         gt_q   <= '0;
         lt_q   <= '0;
         eq_q   <= '0;
      end else begin
         st_q   <= st_d;
         cand_q <= cand_d;
         len_q  <= len_d;
         chg_q  <= chg_d;
         err_q  <= err_d;
         gt_q   <= gt_d;
         lt_q   <= lt_d;
         eq_q   <= eq_d;
      end
   end
   always_comb begin
      legal  = bus.in_valid && ({bus.greater, bus.lesser, bus.equal} inside {3'b100, 3'b010, 3'b001});
      rel    = bus.greater ? GREATER : bus.lesser ? LESS : EQUAL;
      st_d   = st_q;
      cand_d = cand_q;
      len_d  = len_q;
      chg_d  = 1'b0;
      err_d  = err_q;
      gt_d   = gt_q;
      lt_d   = lt_q;
      eq_d   = eq_q;
      if (bus.in_valid && !legal) begin
         err_d  = 1'b1;
         len_d  = '0;
         cand_d = UNKNOWN;
      end else if (legal) begin
         cand_d = rel;
         len_d  = (rel != cand_q) ? 4'd1 : (len_q == DB) ? len_q : len_q + 4'd1;
         // candidate is never UNKNOWN here, so state cannot fall back to UNKNOWN
         if (len_d == DB && cand_d != st_q) begin
            st_d  = cand_d;
            chg_d = 1'b1;
         end
         gt_d = (rel == GREATER && gt_q != MAX) ? gt_q + ONE : gt_q;
         lt_d = (rel == LESS && lt_q != MAX) ? lt_q + ONE : lt_q;
         eq_d = (rel == EQUAL && eq_q != MAX) ? eq_q + ONE : eq_q;
      end
      if (bus.clr_cnt) begin
         gt_d = '0;
         lt_d = '0;
         eq_d = '0;
      end
   end
   assign bus.state     = st_q;
   assign bus.state_chg = chg_q;
   assign bus.run_len   = len_q;
   assign bus.gt_cnt    = gt_q;
   assign bus.lt_cnt    = lt_q;
   assign bus.eq_cnt    = eq_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_compare_result_tracker.sv
// tb_compare_result_tracker: directed and random stimulus with a reference model feeding
// an expected-result queue that is popped after each clock edge
module tb_compare_result_tracker;
   localparam int D = 3;
   localparam int W = 2;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [1:0] state;
      logic       chg;
      logic [3:0] len;
      logic [W-1:0] gt, lt, eq;
      logic       err;
   } exp_t;
   exp_t sb[$];
   logic [1:0]   m_st, m_cand;
   logic [3:0]   m_len;
   logic         m_chg, m_err;
   logic [W-1:0] m_gt, m_lt, m_eq;
   compare_result_if #(.CNT_W(W)) bus ();
   compare_result_tracker #(.DEBOUNCE(D), .CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic model(input logic r, input logic v, input logic g, input logic l, input logic e, input logic c);
      logic [1:0] rel;
      if (r) begin
         m_st = 0; m_cand = 0; m_len = 0; m_chg = 0; m_err = 0; m_gt = 0; m_lt = 0; m_eq = 0;
         return;
      end
      m_chg = 0;
      if (v) begin
         if (int'(g) + int'(l) + int'(e) != 1) begin
            m_err = 1; m_len = 0; m_cand = 0;
         end else begin
            rel = g ? 2'b11 : l ? 2'b01 : 2'b10;
            if (rel == m_cand) m_len = (m_len < 4'(D)) ? m_len + 4'd1 : m_len;
            else begin
               m_cand = rel; m_len = 1;
            end
            if (m_len == 4'(D) && m_cand != m_st) begin
               m_st = m_cand; m_chg = 1;
            end
            if (rel == 2'b11 && m_gt != '1) m_gt++;
            if (rel == 2'b01 && m_lt != '1) m_lt++;
            if (rel == 2'b10 && m_eq != '1) m_eq++;
         end
      end
      if (c) begin
         m_gt = 0; m_lt = 0; m_eq = 0;
      end
   endtask
   task automatic step(input logic r, input logic v, input logic g, input logic l, input logic e, input logic c);
      exp_t x;
      @(negedge clk);
      rst = r; bus.in_valid = v; bus.greater = g; bus.lesser = l; bus.equal = e; bus.clr_cnt = c;
      model(r, v, g, l, e, c);
      x = '{m_st, m_chg, m_len, m_gt, m_lt, m_eq, m_err};
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("state", 8'(bus.state), 8'(x.state));
      chk("state_chg", 8'(bus.state_chg), 8'(x.chg));
      chk("run_len", 8'(bus.run_len), 8'(x.len));
      chk("gt_cnt", 8'(bus.gt_cnt), 8'(x.gt));
      chk("lt_cnt", 8'(bus.lt_cnt), 8'(x.lt));
      chk("eq_cnt", 8'(bus.eq_cnt), 8'(x.eq));
      chk("err", 8'(bus.err), 8'(x.err));
   endtask
   initial begin
      int t3_len[5] = '{1, 2, 1, 1, 2};
      logic [2:0] t3_flags[5] = '{3'b100, 3'b100, 3'b010, 3'b100, 3'b100};
      logic [2:0] f;
      // reset with random flags
      for (int i = 0; i < 2; i++) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_state", 8'(bus.state), 8'h0);
      chk("rst_err", 8'(bus.err), 8'h0);
      // three GREATER samples
      step(0, 1, 1, 0, 0, 0);
      chk("t2_nochg1", 8'(bus.state_chg), 8'h0);
      step(0, 1, 1, 0, 0, 0);
      chk("t2_state_before", 8'(bus.state), 8'h0);
      step(0, 1, 1, 0, 0, 0);
      chk("t2_state", 8'(bus.state), 8'h3);
      chk("t2_chg", 8'(bus.state_chg), 8'h1);
      chk("t2_gt", 8'(bus.gt_cnt), 8'h3);
      step(0, 1, 1, 0, 0, 0);
      chk("t2_no_repulse", 8'(bus.state_chg), 8'h0);
      chk("t2_len_sat", 8'(bus.run_len), 8'(D));
      // broken run
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, t3_flags[i][2], t3_flags[i][1], t3_flags[i][0], 0);
         chk("t3_len", 8'(bus.run_len), 8'(t3_len[i]));
         chk("t3_state", 8'(bus.state), 8'h0);
      end
      // gaps in valid do not break a run
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0);
      step(0, 1, 1, 0, 0, 0);
      chk("t4_state_mid", 8'(bus.state), 8'h0);
      step(0, 1, 1, 0, 0, 0);
      chk("t4_state", 8'(bus.state), 8'h3);
      // illegal flags, then a legal LESS run
      step(0, 1, 1, 1, 0, 0);
      chk("t5_err", 8'(bus.err), 8'h1);
      chk("t5_len", 8'(bus.run_len), 8'h0);
      chk("t5_state_hold", 8'(bus.state), 8'h3);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0);
      chk("t5_state_less", 8'(bus.state), 8'h1);
      chk("t5_err_sticky", 8'(bus.err), 8'h1);
      step(0, 1, 0, 0, 0, 0);
      chk("t5_zero_flags_len", 8'(bus.run_len), 8'h0);
      // counter saturation and clear priority
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0);
      chk("t6_eq_sat", 8'(bus.eq_cnt), 8'h3);
      chk("t6_state_eq", 8'(bus.state), 8'h2);
      step(0, 1, 0, 0, 1, 1);
      chk("t6_eq_clr", 8'(bus.eq_cnt), 8'h0);
      chk("t6_state_kept", 8'(bus.state), 8'h2);
      // random traffic with occasional reset
      for (int i = 0; i < 300; i++) begin
         f = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b001 << $urandom_range(0, 2);
         step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, f[2], f[1], f[0], $urandom_range(0, 15) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
